wr_control: RTL and testbench
=============================

// Module: wr_control
// PURPOSE
//  Generates skewed per-bank write enables and addresses that store one result tile
//  from the systolic array's output edge into the banked result memory (memArr).
//  It is the write-side counterpart of the read sequencer that feeds the array.
//  Bank i writes L consecutive rows starting i cycles after bank 0 (diagonal wavefront).
//  It is driven by the top-level controller through a start/busy/done handshake.
// PARAMETERS
//  WIDTH_HEIGHT  16  array edge length = number of memory banks
//  ADDR_W        8   per-bank address width
// PORTS
//  clk        in   1                     clock
//  reset      in   1                     synchronous, active-high
//  start      in   1                     request a tile write; sampled only in IDLE
//  base_addr  in   ADDR_W                first row address, same for every bank
//  len        in   ADDR_W+1              rows per bank L; legal range 0..2^ADDR_W
//  wr_en      out  WIDTH_HEIGHT          bit i = write strobe for bank i
//  wr_addr    out  WIDTH_HEIGHT*ADDR_W   slice [i*ADDR_W +: ADDR_W] = bank i address
//  busy       out  1                     tile write in progress
//  done       out  1                     1-cycle pulse when the tile write completes
// BEHAVIOUR
//  Reset: wr_en=0, wr_addr=0, busy=0, done=0, state=IDLE, and all latches cleared.
//   Reset has priority in every state. Asserting it mid-tile aborts the tile, and done is not pulsed.
//  All outputs are registers. There is no combinational path from inputs to outputs.
//  FSM states: IDLE, RUN, FIN.
//   IDLE: start=1 at edge E0 -> latch base_addr and len, clear cycle counter t.
//    If len!=0: go to RUN. The cycle after E0 carries t=0 outputs (wr_en=...0001) and busy=1.
//    If len==0: go to FIN. No write occurs, and done pulses in the cycle after E0.
//   RUN: t increments each cycle.
//    wr_en[i] = (t >= i) && (t < i+L).
//    bank i address = base + (t - i), truncated mod 2^ADDR_W so it wraps FF->00.
//    Address slice = 0 whenever wr_en[i]=0.
//    Last write cycle is t = L+WIDTH_HEIGHT-2, after which the FSM goes to FIN.
//    The tile takes L+WIDTH_HEIGHT-1 write cycles in total.
//   FIN: for one cycle, done=1, busy=0, wr_en=0, wr_addr=0. Then go to IDLE.
//    start is ignored in FIN.
//  start in RUN or FIN is ignored, with no queueing.
//   In IDLE, start is accepted in the cycle immediately after the done pulse.
//  base_addr and len are sampled only at acceptance.
//   Later changes do not affect the tile in flight.
//  Counter t is wide enough for 2^ADDR_W+WIDTH_HEIGHT-1 without overflow.
//   len=2^ADDR_W makes each bank visit every address exactly once.
//  Each bank is enabled for exactly L cycles, and those cycles are contiguous.
//   Popcount(wr_en) never exceeds min(L, WIDTH_HEIGHT).
// CONFIGURATION
//  WR_CONTROL_STALL_EN defined:
//   Adds input port `stall` (1 bit), placed after len.
//   stall=1 in RUN freezes t and registers wr_en=0 and wr_addr=0 for that cycle.
//    busy stays 1.
//   When stall returns to 0, the sequence resumes at the frozen t. No write is skipped or repeated.
//   stall has no effect in IDLE or FIN. reset still overrides stall.
//  WR_CONTROL_STALL_EN undefined:
//   The stall port does not exist, and RUN advances t every cycle.
// TESTING
//  The bench is run with WIDTH_HEIGHT=4 and ADDR_W=8 unless a scenario says otherwise.
//  1 Basic: base=10, len=3, start pulse.
//    Expected wr_en = 0001,0011,0111,1110,1100,1000, then done=1 and busy=0.
//    Bank0 addresses 10,11,12. Bank3 addresses 10,11,12 in cycles t=3..5.
//  2 Wrap: base=8'hFE, len=3.
//    Each bank writes FE, FF, 00 in turn. The total is 12 strobes.
//  3 Edge lengths: len=0 gives no wr_en and done one cycle after start.
//    len=1 gives wr_en = 0001,0010,0100,1000, all at address base.
//  4 Handshake: hold start high continuously with len=2.
//    Tiles run back to back, each separated by exactly one FIN cycle.
//    Changing base_addr mid-tile has no effect on the current tile.
//  5 Reset mid-tile: assert reset at t=2.
//    Next cycle all outputs are 0 with no done pulse.
//    A new start after reset replays the tile from t=0.
//  6 (STALL_EN) len=3, stall=1 at t=2 for 2 cycles.
//    Expect two all-zero wr_en cycles, then 0111 resumes. The total tile is 8 cycles.

Source files
------------

// File: rtl/wr_control.sv
// rtl/wr_control.sv - skewed per-bank write sequencer storing one systolic result tile into memArr
// Optional build macro: WR_CONTROL_STALL_EN (adds the stall input).
module wr_control #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [ADDR_W:0]                len,
`ifdef WR_CONTROL_STALL_EN
  input  logic                           stall,
`endif
  output logic [WIDTH_HEIGHT-1:0]        wr_en,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] wr_addr,
  output logic                           busy,
  output logic                           done
);

  localparam int T_W = $clog2((1 << ADDR_W) + WIDTH_HEIGHT);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                         state, state_n;
  logic [T_W-1:0]                 cnt, cnt_n, t_emit;
  logic [ADDR_W-1:0]              base_q, base_n;
  logic [ADDR_W:0]                len_q, len_n;
  logic                           emit;
  logic                           stall_i;
  logic [WIDTH_HEIGHT-1:0]        wr_en_d;
  logic [WIDTH_HEIGHT*ADDR_W-1:0] wr_addr_d;

`ifdef WR_CONTROL_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  // cnt is the index of the next write to issue; outputs are registered from
  // the next-state view so the write for index t appears the cycle it is chosen.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    base_n    = base_q;
    len_n     = len_q;
    emit      = 1'b0;
    t_emit    = cnt;
    wr_en_d   = '0;
    wr_addr_d = '0;
    case (state)
      IDLE: begin
        if (start) begin
          base_n = base_addr;
          len_n  = len;
          if (len != '0) begin
            state_n = RUN;
            emit    = 1'b1;
            t_emit  = '0;
            cnt_n   = T_W'(1);
          end else begin
            state_n = FIN;
          end
        end
      end
      RUN: begin
        if (!stall_i) begin
          if (cnt == T_W'(len_q) + T_W'(WIDTH_HEIGHT - 1)) begin
            state_n = FIN;
          end else begin
            emit  = 1'b1;
            cnt_n = cnt + T_W'(1);
          end
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    for (int i = 0; i < WIDTH_HEIGHT; i++) begin
      if (emit && (t_emit >= T_W'(i)) && (t_emit < T_W'(i) + T_W'(len_n))) begin
        wr_en_d[i] = 1'b1;
        wr_addr_d[i*ADDR_W +: ADDR_W] = base_n + ADDR_W'(t_emit - T_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      base_q  <= '0;
      len_q   <= '0;
      wr_en   <= '0;
      wr_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      base_q  <= base_n;
      len_q   <= len_n;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      busy    <= (state_n == RUN);
      done    <= (state_n == FIN);
    end
  end

endmodule

// File: tb/tb_wr_control.sv
// tb/tb_wr_control.sv - self-checking bench for wr_control (WIDTH_HEIGHT=4, ADDR_W=8)
module tb_wr_control;

  localparam int WH = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          stall;
  logic [WH-1:0] wr_en;
  logic [WH*AW-1:0] wr_addr;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  wr_control #(.WIDTH_HEIGHT(WH), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
`ifdef WR_CONTROL_STALL_EN
    .stall     (stall),
`endif
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: each bank i owns rows base+j (j<L), written in cycle i+j of the tile.
  // Stall cycles (zeros) are inserted after write index stall_at.
  task automatic run_tile(input logic [7:0] b, input logic [8:0] l, input bit keep,
                          input int stall_at, input int stall_n, output int strobes);
    logic [WH-1:0]    e_en   [0:299];
    logic [WH*AW-1:0] e_addr [0:299];
    logic [7:0]       row;
    int n, idx, z;
    for (int k = 0; k < 300; k++) begin
      e_en[k] = '0;
      e_addr[k] = '0;
    end
    for (int i = 0; i < WH; i++) begin
      for (int j = 0; j < int'(l); j++) begin
        row = b + 8'(j);
        e_en[i+j][i] = 1'b1;
        e_addr[i+j][i*AW +: AW] = row;
      end
    end
    n = (l == 0) ? 0 : int'(l) + WH - 1;
    strobes = 0;
    @(negedge clk);
    chk("idle_en", 64'(wr_en), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_done", 64'(done), 64'(0));
    start = 1'b1;
    base_addr = b;
    len = l;
    idx = 0;
    z = 0;
    while (idx < n || z > 0) begin
      @(negedge clk);
      if (!keep) start = 1'b0;
      base_addr = 8'($urandom);
      len = 9'($urandom);
      if (z > 0) begin
        chk("stall_en", 64'(wr_en), 64'(0));
        chk("stall_addr", 64'(wr_addr), 64'(0));
        z--;
        if (z == 0) stall = 1'b0;
      end else begin
        chk($sformatf("en b%0h l%0d t%0d", b, l, idx), 64'(wr_en), 64'(e_en[idx]));
        chk($sformatf("addr b%0h l%0d t%0d", b, l, idx), 64'(wr_addr), 64'(e_addr[idx]));
        strobes += $countones(wr_en);
        idx++;
        if (idx == stall_at && stall_n > 0) begin
          stall = 1'b1;
          z = stall_n;
        end
      end
      chk("run_busy", 64'(busy), 64'(1));
      chk("run_done", 64'(done), 64'(0));
    end
    @(negedge clk);
    if (!keep) start = 1'b0;
    chk($sformatf("fin_done l%0d", l), 64'(done), 64'(1));
    chk("fin_busy", 64'(busy), 64'(0));
    chk("fin_en", 64'(wr_en), 64'(0));
    chk("fin_addr", 64'(wr_addr), 64'(0));
  endtask

  initial begin
    int s;
    logic [7:0] rb;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 64'(wr_en), 64'(0));
    chk("rst_addr", 64'(wr_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    reset = 1'b0;

    run_tile(8'd10, 9'd3, 1'b0, -1, 0, s);
    chk("basic_strobes", 64'(s), 64'(12));
    run_tile(8'hFE, 9'd3, 1'b0, -1, 0, s);
    chk("wrap_strobes", 64'(s), 64'(12));
    run_tile(8'h33, 9'd0, 1'b0, -1, 0, s);
    chk("len0_strobes", 64'(s), 64'(0));
    run_tile(8'h44, 9'd1, 1'b0, -1, 0, s);
    chk("len1_strobes", 64'(s), 64'(4));

    run_tile(8'h20, 9'd2, 1'b1, -1, 0, s);
    run_tile(8'h80, 9'd2, 1'b1, -1, 0, s);
    run_tile(8'hC0, 9'd2, 1'b0, -1, 0, s);

    rb = 8'($urandom);
    run_tile(rb, 9'd256, 1'b0, -1, 0, s);
    chk("full_strobes", 64'(s), 64'(1024));

    repeat (6) begin
      rb = 8'($urandom);
      run_tile(rb, 9'($urandom_range(1, 12)), 1'b0, -1, 0, s);
    end

    // Reset at t=2 aborts the tile with no done pulse.
    rb = 8'($urandom);
    @(negedge clk);
    start = 1'b1;
    base_addr = rb;
    len = 9'd5;
    @(negedge clk);
    start = 1'b0;
    chk("rm_t0", 64'(wr_en), 64'(4'b0001));
    @(negedge clk);
    chk("rm_t1", 64'(wr_en), 64'(4'b0011));
    @(negedge clk);
    chk("rm_t2", 64'(wr_en), 64'(4'b0111));
    reset = 1'b1;
    @(negedge clk);
    chk("rm_en", 64'(wr_en), 64'(0));
    chk("rm_addr", 64'(wr_addr), 64'(0));
    chk("rm_busy", 64'(busy), 64'(0));
    chk("rm_done", 64'(done), 64'(0));
    reset = 1'b0;
    run_tile(rb, 9'd5, 1'b0, -1, 0, s);
    chk("replay_strobes", 64'(s), 64'(20));

`ifdef WR_CONTROL_STALL_EN
    run_tile(8'($urandom), 9'd3, 1'b0, 2, 2, s);
    chk("stall_strobes", 64'(s), 64'(12));
    rb = 8'($urandom);
    run_tile(rb, 9'($urandom_range(2, 9)), 1'b0, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), s);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
